// File: rtl/tile_stepper_square_object_pkg.sv
// ============================================================================
// Module   : tile_stepper_square_object_pkg
// Purpose  : Shared types and constants for tile-stepping sprite movers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tile_stepper_square_object_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVING    = 2'd1,
        ST_RETURNING = 2'd2
    } state_t;

    // moveReq is packed {up, down, left, right}
    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_UP    = 3;

    localparam logic [3:0] MOVE_RIGHT = 4'b0001 << DIR_RIGHT;
    localparam logic [3:0] MOVE_LEFT  = 4'b0001 << DIR_LEFT;
    localparam logic [3:0] MOVE_DOWN  = 4'b0001 << DIR_DOWN;
    localparam logic [3:0] MOVE_UP    = 4'b0001 << DIR_UP;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    // One clamped step from cur toward tgt; never passes tgt.
    function automatic logic signed [11:0] step_toward(
        input logic signed [11:0] cur,
        input logic signed [11:0] tgt,
        input logic signed [11:0] step
    );
        logic signed [11:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + step;
            if (nxt > tgt) nxt = tgt;
        end else if (cur > tgt) begin
            nxt = cur - step;
            if (nxt < tgt) nxt = tgt;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_stepper_square_object_draw.sv
// ============================================================================
// Module   : square_bracket_draw
// Purpose  : Registered inside test, offset and colour for a rectangular sprite.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module square_bracket_draw
    import tile_stepper_square_object_pkg::*;
#(
    parameter int         OBJECT_WIDTH_X  = 32,
    parameter int         OBJECT_HEIGHT_Y = 32,
    parameter logic [7:0] OBJECT_COLOR    = 8'h9E
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [10:0] pixelX,
    input  logic signed [10:0] pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    output logic [10:0]        offsetX,
    output logic [10:0]        offsetY,
    output logic               drawingRequest,
    output logic [7:0]         RGBout
);

    localparam logic signed [11:0] c_width  = 12'(OBJECT_WIDTH_X);
    localparam logic signed [11:0] c_height = 12'(OBJECT_HEIGHT_Y);

    logic signed [11:0] w_px, w_py, w_tlx, w_tly;
    logic               w_inside;

    // Widen before comparing so the right/bottom edge cannot wrap.
    assign w_px  = {pixelX[10], pixelX};
    assign w_py  = {pixelY[10], pixelY};
    assign w_tlx = {topLeftX[10], topLeftX};
    assign w_tly = {topLeftY[10], topLeftY};

    assign w_inside = (w_px >= w_tlx) && (w_px < w_tlx + c_width) &&
                      (w_py >= w_tly) && (w_py < w_tly + c_height);

    logic [10:0] r_offset_x, r_offset_y;
    logic        r_drawing;
    logic [7:0]  r_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_offset_x <= '0;
            r_offset_y <= '0;
            r_drawing  <= 1'b0;
            r_rgb      <= TRANSPARENT_ENCODING;
        end else if (w_inside) begin
            r_offset_x <= pixelX - topLeftX;
            r_offset_y <= pixelY - topLeftY;
            r_drawing  <= 1'b1;
            r_rgb      <= OBJECT_COLOR;
        end else begin
            r_offset_x <= '0;
            r_offset_y <= '0;
            r_drawing  <= 1'b0;
            r_rgb      <= TRANSPARENT_ENCODING;
        end
    end

    assign offsetX        = r_offset_x;
    assign offsetY        = r_offset_y;
    assign drawingRequest = r_drawing;
    assign RGBout         = r_rgb;

endmodule

`default_nettype wire

// File: rtl/tile_stepper_square_object.sv
// ============================================================================
// Module   : tile_stepper_square_object
// Purpose  : Square sprite that glides one tile per move command and bounces
//            back to its starting tile on collision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_stepper_square_object
    import tile_stepper_square_object_pkg::*;
#(
    parameter int         OBJECT_WIDTH_X  = 32,
    parameter int         OBJECT_HEIGHT_Y = 32,
    parameter int         INIT_X          = 32,
    parameter int         INIT_Y          = 32,
    parameter int         TILE_SIZE       = 32,
    parameter int         STEP_PIXELS     = 4,
    parameter int         MIN_X           = 0,
    parameter int         MAX_X           = 640,
    parameter int         MIN_Y           = 0,
    parameter int         MAX_Y           = 480,
    parameter logic [7:0] OBJECT_COLOR    = 8'h9E
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic signed [10:0] pixelX,
    input  logic signed [10:0] pixelY,
    input  logic [3:0]         moveReq,
    input  logic               collision,
    output logic [10:0]        offsetX,
    output logic [10:0]        offsetY,
    output logic               drawingRequest,
    output logic [7:0]         RGBout,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               busy
);

    localparam logic signed [11:0] c_init_x = 12'(INIT_X);
    localparam logic signed [11:0] c_init_y = 12'(INIT_Y);
    localparam logic signed [11:0] c_tile   = 12'(TILE_SIZE);
    localparam logic signed [11:0] c_step   = 12'(STEP_PIXELS);
    localparam logic signed [11:0] c_width  = 12'(OBJECT_WIDTH_X);
    localparam logic signed [11:0] c_height = 12'(OBJECT_HEIGHT_Y);
    localparam logic signed [11:0] c_min_x  = 12'(MIN_X);
    localparam logic signed [11:0] c_max_x  = 12'(MAX_X);
    localparam logic signed [11:0] c_min_y  = 12'(MIN_Y);
    localparam logic signed [11:0] c_max_y  = 12'(MAX_Y);

    state_t             r_state, w_next_state;
    logic signed [11:0] r_pos_x, r_pos_y, w_next_pos_x, w_next_pos_y;
    logic signed [11:0] r_origin, r_target, w_next_origin, w_next_target;
    logic               r_axis_y, w_next_axis_y;
    logic               r_coll_latch, w_next_latch;

    logic signed [11:0] w_cur, w_stepped, w_req_target;
    logic               w_req_valid, w_req_axis_y, w_req_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pos_x      <= c_init_x;
            r_pos_y      <= c_init_y;
            r_origin     <= '0;
            r_target     <= '0;
            r_axis_y     <= 1'b0;
            r_coll_latch <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_pos_x      <= w_next_pos_x;
            r_pos_y      <= w_next_pos_y;
            r_origin     <= w_next_origin;
            r_target     <= w_next_target;
            r_axis_y     <= w_next_axis_y;
            r_coll_latch <= w_next_latch;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_pos_x  = r_pos_x;
        w_next_pos_y  = r_pos_y;
        w_next_origin = r_origin;
        w_next_target = r_target;
        w_next_axis_y = r_axis_y;
        w_next_latch  = r_coll_latch;
        w_req_valid   = 1'b1;
        w_req_axis_y  = 1'b0;
        w_req_target  = r_pos_x;

        w_cur     = r_axis_y ? r_pos_y : r_pos_x;
        w_stepped = step_toward(w_cur, r_target, c_step);

        case (moveReq)
            MOVE_RIGHT: w_req_target = r_pos_x + c_tile;
            MOVE_LEFT:  w_req_target = r_pos_x - c_tile;
            MOVE_DOWN:  begin w_req_axis_y = 1'b1; w_req_target = r_pos_y + c_tile; end
            MOVE_UP:    begin w_req_axis_y = 1'b1; w_req_target = r_pos_y - c_tile; end
            default:    w_req_valid = 1'b0;
        endcase

        // The whole bracket must land inside the legal span.
        w_req_legal = w_req_valid &&
            (w_req_axis_y ? (w_req_target >= c_min_y && w_req_target + c_height <= c_max_y)
                          : (w_req_target >= c_min_x && w_req_target + c_width  <= c_max_x));

        case (r_state)
            ST_IDLE: begin
                if (startOfFrame && w_req_legal) begin
                    w_next_state  = ST_MOVING;
                    w_next_axis_y = w_req_axis_y;
                    w_next_origin = w_req_axis_y ? r_pos_y : r_pos_x;
                    w_next_target = w_req_target;
                    w_next_latch  = 1'b0;
                end
            end
            ST_MOVING: begin
                if (startOfFrame) begin
                    if (r_coll_latch || collision) begin
                        w_next_state  = ST_RETURNING;
                        w_next_target = r_origin;
                        w_next_latch  = 1'b0;
                    end else begin
                        if (r_axis_y) w_next_pos_y = w_stepped;
                        else          w_next_pos_x = w_stepped;
                        if (w_stepped == r_target) w_next_state = ST_IDLE;
                    end
                end else if (collision) begin
                    w_next_latch = 1'b1;
                end
            end
            ST_RETURNING: begin
                w_next_latch = 1'b0;
                if (startOfFrame) begin
                    if (r_axis_y) w_next_pos_y = w_stepped;
                    else          w_next_pos_x = w_stepped;
                    if (w_stepped == r_target) w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    assign topLeftX = r_pos_x[10:0];
    assign topLeftY = r_pos_y[10:0];

    square_bracket_draw #(
        .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y),
        .OBJECT_COLOR   (OBJECT_COLOR)
    ) u_draw (
        .clk           (clk),
        .reset         (reset),
        .pixelX        (pixelX),
        .pixelY        (pixelY),
        .topLeftX      (topLeftX),
        .topLeftY      (topLeftY),
        .offsetX       (offsetX),
        .offsetY       (offsetY),
        .drawingRequest(drawingRequest),
        .RGBout        (RGBout)
    );

endmodule

`default_nettype wire

// File: tb/tb_tile_stepper_square_object.sv
// ============================================================================
// Module   : tb_tile_stepper_square_object
// Purpose  : Directed self-checking bench for tile_stepper_square_object.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_stepper_square_object;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic signed [10:0] pixelX = '0;
    logic signed [10:0] pixelY = '0;
    logic [3:0]         moveReq = '0;
    logic [3:0]         mv12 = '0;
    logic               collision = 1'b0;

    logic [10:0]        offsetX, offsetY, offX12, offY12;
    logic               drawingRequest, busy, dr12, busy12;
    logic [7:0]         RGBout, rgb12;
    logic signed [10:0] topLeftX, topLeftY, tlx12, tly12;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tile_stepper_square_object dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .moveReq(moveReq), .collision(collision),
        .offsetX(offsetX), .offsetY(offsetY), .drawingRequest(drawingRequest),
        .RGBout(RGBout), .topLeftX(topLeftX), .topLeftY(topLeftY), .busy(busy)
    );

    tile_stepper_square_object #(.STEP_PIXELS(12)) dut12 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .moveReq(mv12), .collision(1'b0),
        .offsetX(offX12), .offsetY(offY12), .drawingRequest(dr12),
        .RGBout(rgb12), .topLeftX(tlx12), .topLeftY(tly12), .busy(busy12)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One startOfFrame pulse followed by idle cycles; returns on a negedge.
    task automatic do_frame();
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) startOfFrame = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic request(input logic [3:0] req);
        moveReq = req;
        do_frame();
        moveReq = 4'b0000;
    endtask

    typedef struct {
        int px; int py; int dr; int rgb; int ox; int oy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{40, 50, 1, 'h9E, 8, 18};
        vecs[1] = '{64, 32, 0, 'hFF, 0, 0};
        vecs[2] = '{32, 32, 1, 'h9E, 0, 0};
        vecs[3] = '{63, 63, 1, 'h9E, 31, 31};
        vecs[4] = '{31, 40, 0, 'hFF, 0, 0};
        vecs[5] = '{40, 64, 0, 'hFF, 0, 0};
        vecs[6] = '{-5, 40, 0, 'hFF, 0, 0};
        vecs[7] = '{45, 32, 1, 'h9E, 13, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_x", int'(topLeftX), 32);
        check("reset_y", int'(topLeftY), 32);
        check("reset_busy", int'(busy), 0);
        check("reset_dr", int'(drawingRequest), 0);
        check("reset_rgb", int'(RGBout), 'hFF);
        reset = 1'b0;

        // Frames with no request leave the position alone
        do_frame();
        do_frame();
        check("idle_x", int'(topLeftX), 32);
        check("idle_y", int'(topLeftY), 32);

        // Drawing path, one clock of latency
        for (int i = 0; i < 8; i++) begin
            pixelX = 11'(vecs[i].px);
            pixelY = 11'(vecs[i].py);
            @(negedge clk);
            check($sformatf("draw%0d_dr", i), int'(drawingRequest), vecs[i].dr);
            check($sformatf("draw%0d_rgb", i), int'(RGBout), vecs[i].rgb);
            check($sformatf("draw%0d_ox", i), int'(offsetX), vecs[i].ox);
            check($sformatf("draw%0d_oy", i), int'(offsetY), vecs[i].oy);
        end

        // Collision after three steps bounces back to the origin tile
        request(4'b0001);
        check("col_start_busy", int'(busy), 1);
        check("col_start_x", int'(topLeftX), 32);
        for (int i = 1; i <= 3; i++) begin
            do_frame();
            check($sformatf("col_step%0d_x", i), int'(topLeftX), 32 + 4 * i);
        end
        @(negedge clk) collision = 1'b1;
        @(negedge clk) collision = 1'b0;
        do_frame();
        check("col_hold_x", int'(topLeftX), 44);
        check("col_hold_busy", int'(busy), 1);
        for (int i = 1; i <= 3; i++) begin
            do_frame();
            check($sformatf("ret%0d_x", i), int'(topLeftX), 44 - 4 * i);
            check($sformatf("ret%0d_busy", i), int'(busy), (i == 3) ? 0 : 1);
        end

        // Full move right: 36..64 over 8 frames
        request(4'b0001);
        check("right_start_busy", int'(busy), 1);
        for (int i = 1; i <= 8; i++) begin
            do_frame();
            check($sformatf("right%0d_x", i), int'(topLeftX), 32 + 4 * i);
            check($sformatf("right%0d_busy", i), int'(busy), (i == 8) ? 0 : 1);
        end
        check("right_y", int'(topLeftY), 32);

        // Two moves left reach the left edge
        for (int m = 0; m < 2; m++) begin
            request(4'b0010);
            repeat (8) do_frame();
        end
        check("left_edge_x", int'(topLeftX), 0);
        check("left_edge_busy", int'(busy), 0);

        // Out-of-bounds and multi-hot requests are ignored
        request(4'b0010);
        check("oob_busy", int'(busy), 0);
        do_frame();
        check("oob_x", int'(topLeftX), 0);
        request(4'b0101);
        check("multi_busy", int'(busy), 0);
        do_frame();
        check("multi_x", int'(topLeftX), 0);
        check("multi_y", int'(topLeftY), 32);

        // Vertical move changes only Y
        request(4'b0100);
        repeat (8) do_frame();
        check("down_y", int'(topLeftY), 64);
        check("down_x", int'(topLeftX), 0);
        check("down_busy", int'(busy), 0);

        // Coarse step is clamped on the last frame
        mv12 = 4'b0001;
        do_frame();
        mv12 = 4'b0000;
        check("s12_start_busy", int'(busy12), 1);
        do_frame();
        check("s12_x1", int'(tlx12), 44);
        do_frame();
        check("s12_x2", int'(tlx12), 56);
        do_frame();
        check("s12_x3", int'(tlx12), 64);
        check("s12_busy", int'(busy12), 0);
        do_frame();
        check("s12_settled_x", int'(tlx12), 64);

        // Reset in the middle of a move snaps back asynchronously
        request(4'b0001);
        repeat (8) do_frame();
        request(4'b0001);
        repeat (4) do_frame();
        check("pre_reset_x", int'(topLeftX), 48);
        pixelX = 11'sd50;
        pixelY = 11'sd70;
        @(negedge clk);
        check("pre_reset_dr", int'(drawingRequest), 1);
        #2 reset = 1'b1;
        #1;
        check("async_x", int'(topLeftX), 32);
        check("async_y", int'(topLeftY), 32);
        check("async_busy", int'(busy), 0);
        check("async_dr", int'(drawingRequest), 0);
        check("async_rgb", int'(RGBout), 'hFF);
        check("async_ox", int'(offsetX), 0);
        @(negedge clk) reset = 1'b0;
        do_frame();
        check("post_reset_x", int'(topLeftX), 32);
        check("post_reset_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
